// File: rtl/svn_seg_scan.sv
// -----------------------------------------------------------------------------
// svn_seg_scan
// Time-multiplexed driver for a 3-digit, common-select 7-segment display.
// Each digit gets one slot of SLOT cycles:
//   - BLANK_CYCLES cycles with every select off (anti-ghosting gap),
//   - then DWELL cycles showing that digit.
// A new 12-bit value plus decimal points arrives over valid/ready into a
// one-entry pending buffer. The buffer is copied to the displayed (active)
// value only at a frame boundary, so a frame never shows a mix of old and
// new digits.
//
// Ports
//   clk_i      : clock
//   rst_i      : asynchronous, active-high reset
//   value_i    : hex value, [3:0] = digit 0 (rightmost)
//   dp_i       : decimal point per digit, bit k = digit k
//   valid_i    : value_i/dp_i offered
//   ready_o    : transfer happens when valid_i & ready_o
//   display_o  : segments {dp,g,f,e,d,c,b,a}, level set by LED_POLARITY
//   seg_sel_o  : one-hot digit select, level set by SEL_POLARITY
// -----------------------------------------------------------------------------
module svn_seg_scan #(
  parameter int   CLK_IN_MHZ   = 125,
  parameter int   REFRESH_HZ   = 1000,
  parameter int   BLANK_CYCLES = 64,
  parameter logic LED_POLARITY = 1'b0,
  parameter logic SEL_POLARITY = 1'b0,
  parameter logic LZ_BLANK     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] value_i,
  input  logic [2:0]  dp_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  display_o,
  output logic [2:0]  seg_sel_o
);

  localparam int SLOT  = CLK_IN_MHZ * 1_000_000 / REFRESH_HZ;
  localparam int DWELL = SLOT - BLANK_CYCLES;
  localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  localparam logic [7:0] DISP_OFF = LED_POLARITY ? 8'h00 : 8'hFF;
  localparam logic [2:0] SEL_OFF  = SEL_POLARITY ? 3'b000 : 3'b111;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  generate
    if (DWELL < 1 || BLANK_CYCLES < 1) begin : g_bad_timing
      $error("svn_seg_scan: need BLANK_CYCLES >= 1 and SLOT - BLANK_CYCLES >= 1");
    end
  endgenerate

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  logic [0:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      pend_val_q, pend_val_d;
  logic [2:0]       pend_dp_q, pend_dp_d;
  logic             pend_full_q, pend_full_d;
  logic [11:0]      act_val_q, act_val_d;
  logic [2:0]       act_dp_q, act_dp_d;
  logic [7:0]       display_q, display_d;
  logic [2:0]       sel_q, sel_d;

  logic             frame_start;
  logic             accept;

  // First BLANK cycle of digit 0. True in the very first cycle after reset.
  assign frame_start = (state_q == ST_BLANK) && (idx_q == 2'd0) && (cnt_q == '0);
  // The entry is freed at the boundary, so a new word may land in that cycle.
  assign ready_o     = !pend_full_q || frame_start;
  assign accept      = valid_i && ready_o;

  // Scan sequencer: BLANK -> SHOW -> BLANK, advancing the digit on SHOW exit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (that would infer a latch).
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (state_q == ST_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == DWELL_LAST) begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
    end
  end

  // Pending/active buffers. At a boundary the old pending entry is promoted
  // before a same-cycle accept overwrites pending.
  always_comb begin
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    if (frame_start) begin
      if (pend_full_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_val_d  = value_i;
      pend_dp_d   = dp_i;
      pend_full_d = 1'b1;
    end
  end

  // Pin values for the current state; registered below for clean outputs.
  logic [3:0] nib;
  logic       dp_bit;
  logic       lz_blank;
  logic [2:0] sel_oh;
  logic [7:0] seg_on;

  always_comb begin
    nib      = act_val_q[3:0];
    dp_bit   = act_dp_q[0];
    sel_oh   = 3'b001;
    lz_blank = 1'b0;
    case (idx_q)
      2'd1: begin
        nib      = act_val_q[7:4];
        dp_bit   = act_dp_q[1];
        sel_oh   = 3'b010;
        lz_blank = LZ_BLANK && (act_val_q[11:4] == 8'h00);
      end
      2'd2: begin
        nib      = act_val_q[11:8];
        dp_bit   = act_dp_q[2];
        sel_oh   = 3'b100;
        lz_blank = LZ_BLANK && (act_val_q[11:8] == 4'h0);
      end
      default: ;
    endcase
    // A blanked digit keeps its decimal point.
    seg_on = {dp_bit, lz_blank ? 7'h00 : seg_decode(nib)};
    if (state_q == ST_SHOW) begin
      display_d = LED_POLARITY ? seg_on : ~seg_on;
      sel_d     = SEL_POLARITY ? sel_oh : ~sel_oh;
    end else begin
      display_d = DISP_OFF;
      sel_d     = SEL_OFF;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_BLANK;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      pend_val_q  <= 12'h000;
      pend_dp_q   <= 3'b000;
      pend_full_q <= 1'b0;
      act_val_q   <= 12'h000;
      act_dp_q    <= 3'b000;
      display_q   <= DISP_OFF;
      sel_q       <= SEL_OFF;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      display_q   <= display_d;
      sel_q       <= sel_d;
    end
  end

  assign display_o = display_q;
  assign seg_sel_o = sel_q;

endmodule
